// File: rtl/gsim_banded_solver.sv
// rtl/gsim_banded_solver.sv - Gauss-Seidel solver for the 7-diagonal Toeplitz system (20,-13,6,-1); optional early exit with GSIM_CONV_EN
module gsim_banded_solver #(
    parameter int N        = 16,
    parameter int B_W      = 16,
    parameter int FRAC_W   = 24,
    parameter int ACC_W    = 48,
    parameter int OUT_W    = 32,
    parameter int OUT_FRAC = 16,
    parameter int MAX_ITER = 100,
    parameter int TOL      = 256
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_en,
    input  logic [B_W-1:0]   b_in,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [OUT_W-1:0] x_out,
    output logic [7:0]       iter_cnt
);
    localparam int IW = $clog2(N + 1);
    localparam int SW = $clog2(MAX_ITER + 1);
    localparam int LO = FRAC_W - OUT_FRAC;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SOLVE, S_DRAIN} state_t;

    state_t                  r_state, w_state_nxt;
    logic signed [ACC_W-1:0] r_b [N];
    logic signed [ACC_W-1:0] r_x [N];
    logic [IW-1:0]           r_idx;
    logic [SW-1:0]           r_sweep;
    logic [7:0]              r_iter;

    logic signed [ACC_W-1:0] w_bext;
    logic signed [ACC_W-1:0] w_xm1, w_xm2, w_xm3, w_xp1, w_xp2, w_xp3;
    logic signed [ACC_W-1:0] w_xcur, w_bcur;
    logic signed [ACC_W-1:0] w_p1, w_p2, w_p3, w_s, w_xnew;
    logic                    w_last_row, w_sweep_done, w_early;

    // Reciprocal-of-20 by shift/add: 3/64 * 17/16 * 257/256 * 65537/65536
    function automatic logic signed [ACC_W-1:0] div20(input logic signed [ACC_W-1:0] s);
        logic signed [ACC_W-1:0] t1, t2, t3;
        t1 = ((s >>> 3) + (s >>> 4)) >>> 2;
        t2 = t1 + (t1 >>> 4);
        t3 = t2 + (t2 >>> 8);
        return t3 + (t3 >>> 16);
    endfunction

    assign w_bext = {{(ACC_W-B_W){b_in[B_W-1]}}, b_in} <<< FRAC_W;

    // Fetch the current row and its six band neighbours; rows outside 0..N-1 read as zero
    always_comb begin
        w_xm1 = '0; w_xm2 = '0; w_xm3 = '0;
        w_xp1 = '0; w_xp2 = '0; w_xp3 = '0;
        w_xcur = '0; w_bcur = '0;
        for (int k = 0; k < N; k++) begin
            if (k == int'(r_idx) - 1) w_xm1 = r_x[k];
            if (k == int'(r_idx) - 2) w_xm2 = r_x[k];
            if (k == int'(r_idx) - 3) w_xm3 = r_x[k];
            if (k == int'(r_idx) + 1) w_xp1 = r_x[k];
            if (k == int'(r_idx) + 2) w_xp2 = r_x[k];
            if (k == int'(r_idx) + 3) w_xp3 = r_x[k];
            if (k == int'(r_idx)) begin
                w_xcur = r_x[k];
                w_bcur = r_b[k];
            end
        end
    end

    assign w_p1   = w_xm1 + w_xp1;
    assign w_p2   = w_xm2 + w_xp2;
    assign w_p3   = w_xm3 + w_xp3;
    assign w_s    = w_bcur + (w_p1 <<< 3) + (w_p1 <<< 2) + w_p1
                  - ((w_p2 <<< 2) + (w_p2 <<< 1)) + w_p3;
    assign w_xnew = div20(w_s);

    assign w_last_row   = (r_idx == IW'(N - 1));
    assign w_sweep_done = (r_sweep == SW'(MAX_ITER - 1));

`ifdef GSIM_CONV_EN
    logic                    r_moved;
    logic signed [ACC_W-1:0] w_delta, w_absd;
    logic                    w_moved_now;

    assign w_delta     = w_xnew - w_xcur;
    assign w_absd      = w_delta[ACC_W-1] ? -w_delta : w_delta;
    assign w_moved_now = ($unsigned(w_absd) > ACC_W'(TOL));
    // Early exit needs at least two completed sweeps and no row moved more than TOL in this one
    assign w_early     = !(r_moved || w_moved_now) && (r_sweep != '0);

    // Sticky "some row still moving" flag, restarted at each sweep
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_moved <= 1'b0;
        end else if (r_state == S_SOLVE && !w_last_row) begin
            r_moved <= r_moved | w_moved_now;
        end else begin
            r_moved <= 1'b0;
        end
    end
`else
    assign w_early = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state logic and registered-state-derived outputs
    always_comb begin
        w_state_nxt = r_state;
        busy        = (r_state != S_IDLE);
        out_valid   = (r_state == S_DRAIN);
        out_last    = (r_state == S_DRAIN) && w_last_row;
        x_out       = (r_state == S_DRAIN) ? w_xcur[LO+OUT_W-1:LO] : '0;
        iter_cnt    = r_iter;
        case (r_state)
            S_IDLE:  if (in_en) w_state_nxt = S_LOAD;
            S_LOAD:  if (!in_en) w_state_nxt = (r_idx == IW'(N)) ? S_SOLVE : S_IDLE;
            S_SOLVE: if (w_last_row && (w_sweep_done || w_early)) w_state_nxt = S_DRAIN;
            S_DRAIN: if (out_ready && w_last_row) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Sample storage, in-place row updates, row/sweep counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < N; k++) begin
                r_b[k] <= '0;
                r_x[k] <= '0;
            end
            r_idx   <= '0;
            r_sweep <= '0;
            r_iter  <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (in_en) begin
                    r_b[0] <= w_bext;
                    for (int k = 0; k < N; k++) r_x[k] <= '0;
                    r_idx  <= IW'(1);
                    r_iter <= '0;
                end
                S_LOAD: begin
                    if (in_en) begin
                        for (int k = 0; k < N; k++)
                            if (k == int'(r_idx)) r_b[k] <= w_bext;
                        if (r_idx < IW'(N)) r_idx <= r_idx + IW'(1);
                    end else begin
                        r_idx   <= '0;
                        r_sweep <= '0;
                    end
                end
                S_SOLVE: begin
                    for (int k = 0; k < N; k++)
                        if (k == int'(r_idx)) r_x[k] <= w_xnew;
                    if (w_last_row) begin
                        r_idx   <= '0;
                        r_sweep <= r_sweep + SW'(1);
                        if (r_iter != 8'hFF) r_iter <= r_iter + 8'd1;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                S_DRAIN: if (out_ready) r_idx <= w_last_row ? '0 : r_idx + IW'(1);
                default: r_idx <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_gsim_banded_solver.sv
// tb/tb_gsim_banded_solver.sv - self-checking bench for gsim_banded_solver against a Gauss-Seidel reference model
module tb_gsim_banded_solver;
    localparam int N        = 16;
    localparam int B_W      = 16;
    localparam int FRAC_W   = 24;
    localparam int ACC_W    = 48;
    localparam int OUT_W    = 32;
    localparam int OUT_FRAC = 16;
    localparam int MAX_ITER = 100;
    localparam int TOL      = 256;
    localparam int LO       = FRAC_W - OUT_FRAC;
    localparam int SOLVE_LIM = N * MAX_ITER + 100;

    logic             clk = 1'b0;
    logic             reset_n, in_en, out_ready;
    logic [B_W-1:0]   b_in;
    logic             busy, out_valid, out_last;
    logic [OUT_W-1:0] x_out;
    logic [7:0]       iter_cnt;

    int     n_vec = 0;
    int     n_err = 0;
    longint m_b [N+4];
    longint m_x [N];

    always #5 clk = ~clk;

    gsim_banded_solver #(
        .N(N), .B_W(B_W), .FRAC_W(FRAC_W), .ACC_W(ACC_W), .OUT_W(OUT_W),
        .OUT_FRAC(OUT_FRAC), .MAX_ITER(MAX_ITER), .TOL(TOL)
    ) dut (
        .clk(clk), .reset_n(reset_n), .in_en(in_en), .b_in(b_in),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .x_out(x_out), .iter_cnt(iter_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint wrap_acc(input longint v);
        return (v <<< (64 - ACC_W)) >>> (64 - ACC_W);
    endfunction

    function automatic longint div20(input longint s);
        longint t1, t2, t3;
        t1 = ((s >>> 3) + (s >>> 4)) >>> 2;
        t2 = t1 + (t1 >>> 4);
        t3 = t2 + (t2 >>> 8);
        return t3 + (t3 >>> 16);
    endfunction

    // Reference: plain Gauss-Seidel sweeps over the banded matrix using a coefficient table
    task automatic model_solve();
        longint s;
        int coef [3];
        coef = '{13, -6, 1};
        for (int i = 0; i < N; i++) m_x[i] = 0;
        for (int it = 0; it < MAX_ITER; it++)
            for (int r = 0; r < N; r++) begin
                s = m_b[r] <<< FRAC_W;
                for (int d = 1; d <= 3; d++) begin
                    if (r - d >= 0) s += coef[d-1] * m_x[r-d];
                    if (r + d < N)  s += coef[d-1] * m_x[r+d];
                end
                m_x[r] = div20(wrap_acc(s));
            end
    endtask

    task automatic rand_b();
        for (int i = 0; i < N + 4; i++) m_b[i] = longint'($urandom_range(0, 4000)) - 2000;
    endtask

    task automatic load_problem(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            @(negedge clk);
            in_en = 1'b1;
            b_in  = B_W'(m_b[i]);
        end
        @(negedge clk);
        in_en = 1'b0;
    endtask

    // mode 0: always ready, 1: ready one cycle in three, 2: random ready
    task automatic drain_check(input string tag, input int mode, input bit rand_en, input bit near_one);
        int cyc = 0;
        int k = 0;
        bit stalled = 1'b0;
        bit rdy;
        logic [OUT_W-1:0] hold = '0;
        logic [OUT_W-1:0] expv;
        longint t;
        int diff;
        model_solve();
        out_ready = 1'b0;
        do begin
            @(negedge clk);
            cyc++;
            if (rand_en && !out_valid) in_en = 1'($urandom_range(0, 1));
        end while (!out_valid && cyc < SOLVE_LIM);
        in_en = 1'b0;
        check({tag, "_latency"}, cyc, N * MAX_ITER + 1);
        if (out_valid !== 1'b1) return;
        check({tag, "_iter_cnt"}, iter_cnt, MAX_ITER);
        cyc = 0;
        while (k < N && cyc < 20 * N) begin
            if (out_valid !== 1'b1) begin
                check({tag, "_valid_drop"}, out_valid, 1);
                break;
            end
            if (stalled) check({tag, "_stall_stable"}, x_out, hold);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 2);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            if (rdy) begin
                t    = m_x[k] >>> LO;
                expv = t[OUT_W-1:0];
                check($sformatf("%s_x%0d", tag, k), x_out, expv);
                check($sformatf("%s_last%0d", tag, k), out_last, (k == N - 1));
                if (near_one) begin
                    diff = int'($signed(x_out)) - 32'h0001_0000;
                    check($sformatf("%s_near1_%0d", tag, k), (diff <= 2 && diff >= -2), 1);
                end
                k++;
                stalled = 1'b0;
            end else begin
                hold    = x_out;
                stalled = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        check({tag, "_rows"}, k, N);
        check({tag, "_valid_after"}, out_valid, 0);
        check({tag, "_busy_after"}, busy, 0);
        check({tag, "_iter_hold"}, iter_cnt, MAX_ITER);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_last"}, out_last, 0);
        check({tag, "_x_out"}, x_out, 0);
        check({tag, "_iter"}, iter_cnt, 0);
    endtask

    task automatic count_valid(input string tag, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        check({tag, "_no_output"}, seen, 0);
    endtask

    initial begin
        reset_n = 1'b0; in_en = 1'b0; b_in = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;

        // all-zero right-hand side
        for (int i = 0; i < N + 4; i++) m_b[i] = 0;
        load_problem(N);
        drain_check("zero", 0, 1'b0, 1'b0);

        // b = A * ones, expect x close to 1.0
        m_b[0] = 12; m_b[1] = -1; m_b[2] = 5;
        for (int i = 3; i < N - 3; i++) m_b[i] = 4;
        m_b[N-3] = 5; m_b[N-2] = -1; m_b[N-1] = 12;
        load_problem(N);
        drain_check("ones", 0, 1'b0, 1'b1);

        // short load is discarded
        rand_b();
        load_problem(7);
        @(negedge clk);
        check("short_busy", busy, 0);
        count_valid("short", 40);

        // same ones problem under 1-in-3 backpressure
        m_b[0] = 12; m_b[1] = -1; m_b[2] = 5;
        for (int i = 3; i < N - 3; i++) m_b[i] = 4;
        m_b[N-3] = 5; m_b[N-2] = -1; m_b[N-1] = 12;
        load_problem(N);
        drain_check("ones_bp", 1, 1'b0, 1'b1);

        // random b, random backpressure, in_en noise during SOLVE
        rand_b();
        load_problem(N);
        drain_check("rand1", 2, 1'b1, 1'b0);

        // surplus samples after N are ignored
        rand_b();
        load_problem(N + 3);
        drain_check("extra", 2, 1'b0, 1'b0);

        // reset pulse during SOLVE aborts the problem
        rand_b();
        load_problem(N);
        repeat (300) @(negedge clk);
        check("pre_abort_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        reset_n = 1'b1;
        count_valid("abort", 2 * N * MAX_ITER / 2 + 50);

        // recovery with a fresh random problem
        rand_b();
        load_problem(N);
        drain_check("rand2", 1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
